ssm_scan_ctrl: RTL and testbench



---
 rtl/ssm_scan_ctrl_if.sv | 43 ++++
 rtl/ssm_scan_ctrl.sv | 152 +++++++++++++++
 tb/tb_ssm_scan_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ssm_scan_ctrl_if.sv
// Bundle between the scan sequencer and its operand/result memories and datapath.
// Latency: none, wires only.
// Backpressure: tile_ready_i stalls tile issue; results are never backpressured.
interface ssm_scan_ctrl_if #(
  parameter int H      = 24,
  parameter int P      = 64,
  parameter int N      = 128,
  parameter int N_TILE = 16,
  parameter int DW     = 16
);
  localparam int TILES = N / N_TILE;
  localparam int HW    = $clog2(H);
  localparam int PW    = $clog2(P);
  localparam int TW    = (TILES > 1) ? $clog2(TILES) : 1;
  localparam int IW    = $clog2(H * P);

  logic          start_i;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [HW-1:0] h_idx_o;
  logic [PW-1:0] p_idx_o;
  logic [TW-1:0] tile_idx_o;
  logic          tile_valid_o;
  logic          tile_ready_i;
  logic          y_valid_i;
  logic [DW-1:0] y_i;
  logic          y_we_o;
  logic [IW-1:0] y_addr_o;
  logic [DW-1:0] y_data_o;

  modport master (
    input  start_i, tile_ready_i, y_valid_i, y_i,
    output busy_o, done_o, err_o, h_idx_o, p_idx_o, tile_idx_o, tile_valid_o,
           y_we_o, y_addr_o, y_data_o
  );

  modport slave (
    output start_i, tile_ready_i, y_valid_i, y_i,
    input  busy_o, done_o, err_o, h_idx_o, p_idx_o, tile_idx_o, tile_valid_o,
           y_we_o, y_addr_o, y_data_o
  );
endinterface

// File: rtl/ssm_scan_ctrl.sv
// Walks all (h,p) pairs issuing TILES state tiles each, and writes returned results to h*P+p.
// Latency: tile 0 one cycle after start; result write one cycle after y_valid_i.
// Backpressure: indices hold while tile_ready_i=0; new pairs throttled when DEPTH pairs are in flight.
module ssm_scan_ctrl #(
  parameter int H      = 24,
  parameter int P      = 64,
  parameter int N      = 128,
  parameter int N_TILE = 16,
  parameter int DW     = 16,
  parameter int DEPTH  = 8
) (
  input logic             clk,
  input logic             rst,
  ssm_scan_ctrl_if.master bus
);
  localparam int TILES = N / N_TILE;
  localparam int HW    = $clog2(H);
  localparam int PW    = $clog2(P);
  localparam int TW    = (TILES > 1) ? $clog2(TILES) : 1;
  localparam int IW    = $clog2(H * P);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [HW-1:0] h;
  logic [PW-1:0] p;
  logic [TW-1:0] t;
  logic [IW-1:0] idx_mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic          err;
  logic          we;
  logic [IW-1:0] addr;
  logic [DW-1:0] data;

  logic          tile_valid;
  logic          fire;
  logic          last_tile;
  logic          last_p;
  logic          last_h;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic [IW-1:0] pair_idx;

  assign fifo_empty = (count == '0);
  // A new pair may not start while the index FIFO is full; mid-pair tiles always flow.
  assign tile_valid = (state == S_ISSUE) && !((t == '0) && (count == CW'(DEPTH)));
  assign fire       = tile_valid && bus.tile_ready_i;
  assign last_tile  = (t == TW'(TILES - 1));
  assign last_p     = (p == PW'(P - 1));
  assign last_h     = (h == HW'(H - 1));
  assign push       = fire && last_tile;
  assign pop        = bus.y_valid_i && !fifo_empty;
  assign pair_idx   = IW'(h) * IW'(P) + IW'(p);

  // Scan state: issue all tiles, drain outstanding results, pulse done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (bus.start_i) state <= S_ISSUE;
        S_ISSUE: if (push && last_p && last_h) state <= S_DRAIN;
        S_DRAIN: if (fifo_empty && !pop) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tile/pair walk, h outer, p inner; advances only on a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      h <= '0;
      p <= '0;
      t <= '0;
    end else if (state == S_IDLE && bus.start_i) begin
      h <= '0;
      p <= '0;
      t <= '0;
    end else if (fire) begin
      if (last_tile) begin
        t <= '0;
        if (last_p) begin
          p <= '0;
          h <= last_h ? '0 : h + HW'(1);
        end else begin
          p <= p + PW'(1);
        end
      end else begin
        t <= t + TW'(1);
      end
    end
  end

  // Index FIFO storage, written with the pair address when its last tile leaves.
  always_ff @(posedge clk) begin
    if (push) idx_mem[wptr] <= pair_idx;
  end

  // Index FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + AW'(1);
      if (pop)  rptr <= (rptr == AW'(DEPTH - 1)) ? '0 : rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered result write; a result with nothing in flight is flagged instead.
  always_ff @(posedge clk) begin
    if (rst) begin
      we   <= 1'b0;
      addr <= '0;
      data <= '0;
      err  <= 1'b0;
    end else begin
      we <= pop;
      if (pop) begin
        addr <= idx_mem[rptr];
        data <= bus.y_i;
      end
      if (bus.y_valid_i && fifo_empty) err <= 1'b1;
    end
  end

  assign bus.busy_o       = (state != S_IDLE);
  assign bus.done_o       = (state == S_DONE);
  assign bus.err_o        = err;
  assign bus.h_idx_o      = h;
  assign bus.p_idx_o      = p;
  assign bus.tile_idx_o   = t;
  assign bus.tile_valid_o = tile_valid;
  assign bus.y_we_o       = we;
  assign bus.y_addr_o     = addr;
  assign bus.y_data_o     = data;
endmodule

// File: tb/tb_ssm_scan_ctrl.sv
// Directed bench for ssm_scan_ctrl with a cycle model of issue, throttle and result return.
// Latency: datapath model returns each pair's result a programmable number of cycles after its last tile.
// Backpressure: tile_ready_i driven constant or random per phase.
module tb_ssm_scan_ctrl;
  localparam int H      = 2;
  localparam int P      = 3;
  localparam int N      = 64;
  localparam int N_TILE = 16;
  localparam int DW     = 16;
  localparam int DEPTH  = 2;
  localparam int TILES  = N / N_TILE;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ssm_scan_ctrl_if #(.H(H), .P(P), .N(N), .N_TILE(N_TILE), .DW(DW)) bus ();

  ssm_scan_ctrl #(.H(H), .P(P), .N(N), .N_TILE(N_TILE), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {int idx; int due;} pend_t;
  typedef struct {int addr; int data;} exp_t;
  pend_t pipe[$];
  exp_t  sb[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  bit m_busy = 0, m_issuing = 0, m_err = 0, m_we = 0, d1 = 0, d2 = 0, chk_rst = 1;
  int mh = 0, mp = 0, mt = 0, outst = 0;
  bit rnd_ready = 0, do_start = 0, do_spur = 0, do_rst = 0, noise_start = 0;
  int lat = 4;
  int dones = 0, accepts = 0, aborted = 0;
  int dfires = 0, first_fire = -1, last_fire = -1;
  int thr_dut = 0, thr_model = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at the falling edge, then drive inputs for the next rising edge.
  task automatic tick();
    bit    exp_valid, fire, dfire, rdy, st, yv;
    int    yd;
    pend_t pe;
    exp_t  e;
    @(negedge clk);
    exp_valid = m_issuing && !(mt == 0 && outst == DEPTH);
    check("busy", bus.busy_o, m_busy);
    check("done", bus.done_o, d2);
    check("err", bus.err_o, m_err);
    check("tile_valid", bus.tile_valid_o, exp_valid);
    if (exp_valid) begin
      check("h_idx", bus.h_idx_o, mh);
      check("p_idx", bus.p_idx_o, mp);
      check("tile_idx", bus.tile_idx_o, mt);
    end
    check("y_we", bus.y_we_o, m_we);
    if (bus.y_we_o === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        e = sb.pop_front();
        check("y_addr", bus.y_addr_o, e.addr);
        check("y_data", bus.y_data_o, e.data);
      end
    end
    if (chk_rst) begin
      check("rst_h", bus.h_idx_o, 0);
      check("rst_p", bus.p_idx_o, 0);
      check("rst_t", bus.tile_idx_o, 0);
      check("rst_addr", bus.y_addr_o, 0);
      check("rst_data", bus.y_data_o, 0);
      chk_rst = 0;
    end
    if (bus.done_o === 1'b1) dones++;
    if (m_issuing && bus.tile_valid_o !== 1'b1) thr_dut++;
    if (m_issuing && !exp_valid) thr_model++;
    if (d2) m_busy = 0;
    d2 = d1;
    d1 = 0;
    m_we = 0;

    if (do_rst) begin
      do_rst = 0;
      rst = 1'b1;
      bus.start_i = 1'b0;
      bus.y_valid_i = 1'b0;
      bus.y_i = '0;
      bus.tile_ready_i = 1'b0;
      if (m_busy) aborted++;
      m_busy = 0; m_issuing = 0; m_err = 0;
      mh = 0; mp = 0; mt = 0; outst = 0;
      pipe.delete();
      sb.delete();
      chk_rst = 1;
    end else begin
      rst = 1'b0;
      rdy = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.tile_ready_i = rdy;
      fire  = exp_valid && rdy;
      dfire = (bus.tile_valid_o === 1'b1) && rdy;
      if (dfire) begin
        dfires++;
        if (first_fire < 0) first_fire = cyc;
        last_fire = cyc;
      end
      st = do_start || (noise_start && m_busy && (cyc % 5 == 2));
      do_start = 0;
      bus.start_i = st;
      yv = 0;
      yd = 0;
      if (do_spur) begin
        do_spur = 0;
        yv = 1;
        yd = $urandom_range(0, 65535);
        if (outst == 0) m_err = 1;
      end else if (pipe.size() > 0 && pipe[0].due <= cyc) begin
        pe = pipe.pop_front();
        yv = 1;
        yd = (pe.idx * 5 + 3) & 16'hFFFF;
        if (outst > 0) begin
          outst--;
          m_we = 1;
          sb.push_back('{addr: pe.idx, data: yd});
        end else begin
          m_err = 1;
        end
      end
      bus.y_valid_i = yv;
      bus.y_i = DW'(yd);
      if (fire) begin
        if (mt == TILES - 1) begin
          pipe.push_back('{idx: mh * P + mp, due: cyc + lat});
          outst++;
          mt = 0;
          if (mp == P - 1) begin
            mp = 0;
            if (mh == H - 1) begin
              mh = 0;
              m_issuing = 0;
            end else mh++;
          end else mp++;
        end else mt++;
      end
      if (st && !m_busy) begin
        m_busy = 1; m_issuing = 1;
        mh = 0; mp = 0; mt = 0;
        accepts++;
      end
      if (m_we && m_busy && !m_issuing && outst == 0 && pipe.size() == 0) d1 = 1;
    end
    cyc++;
  endtask

  // Start a scan and run until done_o is seen or the cycle budget runs out.
  task automatic run_scan(input int budget);
    int n = 0;
    int d0 = dones;
    do_start = 1;
    while (dones == d0 && n < budget) begin
      tick();
      n++;
    end
    check("scan_done_seen", dones - d0, 1);
    tick();
    tick();
    check("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    int f0, n;
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.tile_ready_i = 1'b0;
    bus.y_valid_i = 1'b0;
    bus.y_i = '0;

    // Reset values
    do_rst = 1;
    tick();
    tick();
    tick();

    // Full-rate scan: 24 fires back-to-back, pop and push coinciding at pair boundaries
    lat = 4;
    rnd_ready = 0;
    dfires = 0; first_fire = -1;
    run_scan(2000);
    check("fire_count_full_rate", dfires, H * P * TILES);
    check("fire_span_full_rate", last_fire - first_fire, H * P * TILES - 1);

    // Random ready: indices must hold across every stall
    lat = 6;
    rnd_ready = 1;
    dfires = 0;
    run_scan(4000);
    check("fire_count_random_ready", dfires, H * P * TILES);
    rnd_ready = 0;

    // Long latency: index FIFO fills and throttles new pairs at tile 0
    lat = 200;
    thr_dut = 0; thr_model = 0;
    run_scan(5000);
    check("throttle_cycles", thr_dut, thr_model);
    check("throttle_seen", (thr_dut > 0), 1);

    // Stray result while idle sets the sticky error, then a scan still completes
    lat = 3;
    do_spur = 1;
    tick();
    tick();
    check("err_sticky", bus.err_o, 1);
    run_scan(2000);
    check("err_still_set", bus.err_o, 1);

    // Reset after 10 fires, then a clean full scan from (0,0)
    f0 = dfires;
    n = 0;
    do_start = 1;
    while (dfires - f0 < 10 && n < 500) begin
      tick();
      n++;
    end
    check("mid_scan_fires", dfires - f0, 10);
    do_rst = 1;
    tick();
    tick();
    check("err_cleared_by_rst", bus.err_o, 0);
    dfires = 0;
    run_scan(2000);
    check("fire_count_after_rst", dfires, H * P * TILES);

    // Start pulses during ISSUE, DRAIN and DONE are ignored
    lat = 30;
    noise_start = 1;
    run_scan(3000);
    noise_start = 0;
    for (int i = 0; i < 8; i++) tick();
    check("dones_per_accepted_start", dones, accepts - aborted);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
